// File: rtl/frame_fetcher.sv
// frame_fetcher: bus-master client for one bus_arbiter channel.
// Walks a contiguous block of frame memory one word per request. Fetched
// words go into a small first-word-fall-through FIFO that is streamed to a
// downstream LED driver with a valid/ready handshake.
//
// Ports:
//   clk, rst              clock, synchronous active-high reset
//   start, abort          begin transfer (sampled in IDLE) / cancel and flush
//   base_addr, length     first address and word count, latched on start
//   busy, done            not-IDLE flag, one-cycle end-of-transfer pulse
//   bus_req, bus_addr     request side of the arbiter channel
//   bus_data, bus_rdy     response side of the arbiter channel
//   out_data, out_valid   FIFO head and non-empty flag
//   out_ready             downstream accept; pops when out_valid & out_ready
//
// Build option: define FRAME_FETCHER_LOOP_EN to repeat the address range
// forever (done pulses once per pass) until abort or rst.
module frame_fetcher #(
  parameter int ADDRESS_WIDTH = 8,
  parameter int DATA_WIDTH    = 8,
  parameter int LEN_WIDTH     = 16,
  parameter int FIFO_DEPTH    = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic                     abort,
  input  logic [ADDRESS_WIDTH-1:0] base_addr,
  input  logic [LEN_WIDTH-1:0]     length,
  output logic                     busy,
  output logic                     done,
  output logic                     bus_req,
  output logic [ADDRESS_WIDTH-1:0] bus_addr,
  input  logic [DATA_WIDTH-1:0]    bus_data,
  input  logic                     bus_rdy,
  output logic [DATA_WIDTH-1:0]    out_data,
  output logic                     out_valid,
  input  logic                     out_ready
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;

  localparam logic [ADDRESS_WIDTH-1:0] ADDR_ONE = 1;
  localparam logic [LEN_WIDTH-1:0]     LEN_ONE  = 1;
  localparam logic [PTR_W-1:0]         PTR_ONE  = 1;
  localparam logic [CNT_W-1:0]         CNT_ONE  = 1;
  localparam logic [CNT_W-1:0]         CNT_FULL = CNT_W'(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, REQ, RELEASE, DRAIN} state_t;

  state_t                   state_q;
  logic                     bus_req_q;
  logic                     done_q;
  logic [ADDRESS_WIDTH-1:0] cur_addr_q;
  logic [LEN_WIDTH-1:0]     remaining_q;
  logic [ADDRESS_WIDTH-1:0] base_q;
  logic [LEN_WIDTH-1:0]     len_q;

  logic [DATA_WIDTH-1:0]    mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0]         wr_ptr_q;
  logic [PTR_W-1:0]         rd_ptr_q;
  logic [CNT_W-1:0]         count_q;

  logic fifo_empty;
  logic fifo_full;
  logic push;
  logic pop;

  assign fifo_empty = (count_q == '0);
  assign fifo_full  = (count_q == CNT_FULL);
  // abort wins over a same-cycle capture: the word is dropped, not pushed.
  assign push       = (state_q == REQ) && bus_rdy && !abort;
  assign pop        = !fifo_empty && out_ready;

  assign busy      = (state_q != IDLE);
  assign done      = done_q;
  assign bus_req   = bus_req_q;
  assign bus_addr  = cur_addr_q;
  assign out_valid = !fifo_empty;
  assign out_data  = fifo_empty ? '0 : mem_q[rd_ptr_q];

  // Control FSM. bus_req_q is registered alongside the state so it is high
  // exactly while the FSM sits in REQ.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      bus_req_q   <= 1'b0;
      done_q      <= 1'b0;
      cur_addr_q  <= '0;
      remaining_q <= '0;
      base_q      <= '0;
      len_q       <= '0;
    end else begin
      done_q    <= 1'b0;
      bus_req_q <= 1'b0;
      if (abort) begin
        state_q <= IDLE;
      end else begin
        case (state_q)
          IDLE: begin
            if (start) begin
              cur_addr_q  <= base_addr;
              remaining_q <= length;
              base_q      <= base_addr;
              len_q       <= length;
              if (length == '0) begin
                done_q <= 1'b1;
              end else if (!fifo_full) begin
                state_q   <= REQ;
                bus_req_q <= 1'b1;
              end else begin
                state_q <= RELEASE;
              end
            end
          end
          REQ: begin
            if (bus_rdy) begin
              cur_addr_q  <= cur_addr_q + ADDR_ONE;
              remaining_q <= remaining_q - LEN_ONE;
              state_q     <= RELEASE;
            end else begin
              bus_req_q <= 1'b1;
            end
          end
          RELEASE: begin
            // The arbiter lowers rdy one cycle after req falls; never
            // re-request until that has been seen.
            if (!bus_rdy) begin
              if (remaining_q == '0) begin
`ifdef FRAME_FETCHER_LOOP_EN
                cur_addr_q  <= base_q;
                remaining_q <= len_q;
                done_q      <= 1'b1;
                if (!fifo_full) begin
                  state_q   <= REQ;
                  bus_req_q <= 1'b1;
                end
`else
                state_q <= DRAIN;
`endif
              end else if (!fifo_full) begin
                state_q   <= REQ;
                bus_req_q <= 1'b1;
              end
            end
          end
          DRAIN: begin
            if (fifo_empty) begin
              done_q  <= 1'b1;
              state_q <= IDLE;
            end
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  // FIFO bookkeeping. Pushes only happen in REQ, which is entered only with
  // space available, so push-on-full cannot occur.
  always_ff @(posedge clk) begin
    if (rst || abort) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PTR_ONE;
      if (pop)  rd_ptr_q <= rd_ptr_q + PTR_ONE;
      case ({push, pop})
        2'b10:   count_q <= count_q + CNT_ONE;
        2'b01:   count_q <= count_q - CNT_ONE;
        default: count_q <= count_q;
      endcase
    end
  end

  // FIFO storage carries data only and is not reset; out_data is gated
  // while empty so the head reads zero.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= bus_data;
  end

endmodule
